uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte FIFO between `uart_core` receive outputs and `uart_wrapper` receive inputs. It drains received bytes from the core as soon as they arrive and buffers them, so software polling the register space can fall several bytes behind without losing data. Toward the wrapper it presents the same `data_rx` / `have_data_rx` / `data_rx_ack` handshake the core exposes, so it drops into the uart0 path with no wrapper changes. It adds a sticky overflow flag, an occupancy count and a flush input.

## Interface
- `DEPTH`, 8: number of byte entries; must be a power of two, at least 2.
- `ADDR_W`, 3: log2(`DEPTH`); pointer width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `core_data_rx`  in  8  received byte from `uart_core`; valid while `core_have_data_rx` is high.
- `core_have_data_rx`  in  1  core holds an unread byte; level signal, cleared by the core after an ack.
- `core_data_rx_ack`  out  1  one-cycle pulse; tells the core its byte was taken.
- `data_rx`  out  8  byte at the FIFO head; equals 0 when empty.
- `have_data_rx`  out  1  FIFO non-empty.
- `data_rx_ack`  in  1  pop request from the wrapper; one entry per high cycle.
- `flush`  in  1  discard all buffered bytes.
- `overflow`  out  1  sticky: at least one byte was dropped because the FIFO was full.
- `overflow_clr`  in  1  clears `overflow`.
- `count`  out  ADDR_W+1  number of bytes buffered, 0..`DEPTH`.

## Operation
- Storage: `DEPTH` x 8 register array, plus `wr_ptr` and `rd_ptr` (ADDR_W bits each, wrap modulo `DEPTH`) and `count` (ADDR_W+1 bits).
- `empty` = (count == 0); `full` = (count == DEPTH).
- Intake FSM, three states: IDLE, ACK, HOLD.
  - IDLE with `core_have_data_rx` = 1: capture the byte and go to ACK, registering `core_data_rx_ack` = 1.
    - Byte is written if `!full || pop_this_cycle`.
    - Otherwise the byte is discarded and `overflow` is set to 1.
  - ACK: `core_data_rx_ack` = 1 for exactly this cycle, then go to HOLD.
  - HOLD: ignore `core_have_data_rx` (the core clears it during this window), then return to IDLE.
  - A dropped byte is still acked, so the core is always drained and never overruns internally.
- Pop: a cycle with `data_rx_ack` = 1 and `!empty` advances `rd_ptr`. `data_rx_ack` while empty is ignored; no underflow, no flag.
- `data_rx` = mem[rd_ptr] when non-empty, else 8'h00. It is combinational from registered state.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged. Legal even when full.
- `count` update: count + push − pop, never below 0 and never above `DEPTH`.
- `flush`: next edge sets `wr_ptr` = `rd_ptr` = `count` = 0.
  - A byte being captured in that same cycle is discarded, but the intake FSM still completes its ACK/HOLD sequence.
  - `overflow` is not affected by `flush`.
- `overflow_clr`: next edge clears `overflow`. If a drop occurs in the same cycle, the set wins and `overflow` stays 1.
- Reset (`rst` = 1 at an edge), including mid-handshake:
  - FSM goes to IDLE.
  - `core_data_rx_ack` = 0, `have_data_rx` = 0, `data_rx` = 0, `overflow` = 0, `count` = 0, pointers = 0.
  - Array contents need not be cleared.

## Timing
- Intake latency: core byte sampled at edge E; `have_data_rx` and updated `count` are visible from E+1.
- `core_data_rx_ack` is high during the cycle following E, for exactly one cycle.
- Minimum intake spacing is 3 cycles per byte (IDLE→ACK→HOLD→IDLE). A `core_have_data_rx` that stays high through HOLD is treated as a new byte only once the FSM is back in IDLE.
- Pop latency: `data_rx_ack` sampled at edge P; the next head byte (or 0 / `have_data_rx` = 0) is visible from P+1.
- No combinational path from `core_*` inputs to wrapper-side outputs, or from `data_rx_ack` to `core_data_rx_ack`.

## Test plan
- Single byte:
  - Stimulus: core presents 8'hA5 with `have_data_rx` held until ack.
  - Required: one `core_data_rx_ack` pulse, then `have_data_rx` = 1, `data_rx` = 8'hA5, `count` = 1.
  - Then: one `data_rx_ack` → `have_data_rx` = 0, `data_rx` = 0.
- Fill and order:
  - Stimulus: push 8'h00..8'h07 (DEPTH = 8) with no pops.
  - Required: `count` = 8. Eight pops return 8'h00..8'h07 in order, `count` steps 8→0, `overflow` stays 0.
- Overflow:
  - Stimulus: FIFO full, core presents 8'hEE.
  - Required: byte acked and dropped, `overflow` = 1, `count` = 8, head still 8'h00.
  - Then: `overflow_clr` clears it.
  - Then: a drop and `overflow_clr` in the same cycle leave `overflow` = 1.
- Simultaneous push and pop while full:
  - Stimulus: push 8'h99 and pop in the same cycle with FIFO full.
  - Required: `count` stays 8, no overflow. After draining, 8'h99 is the last byte out, with pointer wrap exercised.
- Flush and reset mid-operation:
  - Stimulus: `flush` while 5 bytes are buffered and a capture is in progress.
  - Required: `count` = 0, `have_data_rx` = 0, ack pulse still exactly one cycle.
  - Stimulus: `rst` asserted during ACK.
  - Required: `core_data_rx_ack` = 0 from the next cycle and all outputs at their reset values.
- Empty pop:
  - Stimulus: `data_rx_ack` held high 3 cycles while empty.
  - Required: `count` stays 0, pointers unchanged, no flag.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between uart_core and uart_wrapper.
// Drains bytes from the core as soon as they arrive, buffers up to DEPTH of
// them and re-presents the core's data_rx / have_data_rx / data_rx_ack
// handshake toward the wrapper. Adds a sticky overflow flag, an occupancy
// count and a flush input.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   core_data_rx       byte from uart_core, valid while core_have_data_rx
//   core_have_data_rx  core holds an unread byte (level)
//   core_data_rx_ack   one-cycle pulse telling the core its byte was taken
//   data_rx            byte at the FIFO head, 0 when empty
//   have_data_rx       FIFO non-empty
//   data_rx_ack        pop request, one entry per high cycle
//   flush              discard all buffered bytes
//   overflow           sticky: a byte was dropped because the FIFO was full
//   overflow_clr       clears overflow (a same-cycle drop wins)
//   count              number of buffered bytes, 0..DEPTH
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] core_data_rx,
  input  logic              core_have_data_rx,
  output logic              core_data_rx_ack,
  output logic [DATA_W-1:0] data_rx,
  output logic              have_data_rx,
  input  logic              data_rx_ack,
  input  logic              flush,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [ADDR_W:0]   count
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              capture;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Intake FSM: a capture in IDLE is followed by one ACK cycle and one HOLD
  // cycle, giving the core time to drop its level before we look again.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_have_data_rx) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign core_data_rx_ack = (state_q == ACK);

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = data_rx_ack & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = capture & ~flush & (~full | pop);
  // Dropped bytes are still acked by the FSM so the core never backs up.
  assign drop  = capture & full & ~pop;

  // Storage: data path only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_data_rx;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; flush leaves it alone, a drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign have_data_rx = ~empty;
  assign data_rx      = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus a randomized run, all
// compared against a queue-based behavioural model of the FIFO.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] core_data_rx;
  logic       core_have_data_rx;
  logic       core_data_rx_ack;
  logic [7:0] data_rx;
  logic       have_data_rx;
  logic       data_rx_ack;
  logic       flush;
  logic       overflow;
  logic       overflow_clr;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_ack;
  int         m_busy;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .core_data_rx      (core_data_rx),
    .core_have_data_rx (core_have_data_rx),
    .core_data_rx_ack  (core_data_rx_ack),
    .data_rx           (data_rx),
    .have_data_rx      (have_data_rx),
    .data_rx_ack       (data_rx_ack),
    .flush             (flush),
    .overflow          (overflow),
    .overflow_clr      (overflow_clr),
    .count             (count)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUT take the same edge. Outputs are read 1 time unit later.
  task automatic step();
    bit can_pop, capture, drop;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_busy = 0;
      m_ack  = 1'b0;
    end else begin
      can_pop = data_rx_ack && (mq.size() > 0);
      capture = (m_busy == 0) && core_have_data_rx;
      drop    = capture && (mq.size() == DEPTH) && !can_pop;
      if (can_pop) void'(mq.pop_front());
      if (capture && !flush && !drop) mq.push_back(core_data_rx);
      if (flush) mq.delete();
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_ack = capture;
      if (capture) m_busy = 2;
      else if (m_busy > 0) m_busy--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; core_data_rx = 8'h00; core_have_data_rx = 0;
    data_rx_ack = 0; flush = 0; overflow_clr = 0;
  endtask

  // Core presents a byte, drops its level once acked; FSM back in IDLE after.
  task automatic push_byte(input logic [7:0] b);
    core_data_rx = b; core_have_data_rx = 1;
    step();
    core_have_data_rx = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    checks++;
    if (count !== 4'd0 || have_data_rx !== 1'b0 || data_rx !== 8'h00 ||
        overflow !== 1'b0 || core_data_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d have=%b data=%h ovf=%b ack=%b, required 0 0 00 0 0",
               count, have_data_rx, data_rx, overflow, core_data_rx_ack);
    end
  endtask

  task automatic test_single();
    core_data_rx = 8'hA5; core_have_data_rx = 1;
    step();
    core_have_data_rx = 0;
    checks++;
    if (core_data_rx_ack !== 1'b1 || have_data_rx !== 1'b1 || data_rx !== 8'hA5 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_push: ack=%b have=%b data=%h count=%0d, required 1 1 a5 1",
               core_data_rx_ack, have_data_rx, data_rx, count);
    end
    step();
    checks++;
    if (core_data_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_len: ack=%b, required 0", core_data_rx_ack);
    end
    step();
    data_rx_ack = 1;
    step();
    data_rx_ack = 0;
    checks++;
    if (have_data_rx !== 1'b0 || data_rx !== 8'h00 || count !== 4'd0) begin
      errors++;
      $display("FAIL single_pop: have=%b data=%h count=%0d, required 0 00 0",
               have_data_rx, data_rx, count);
    end
  endtask

  task automatic fill_0_to_7();
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
  endtask

  task automatic test_fill();
    fill_0_to_7();
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL fill_count: count=%0d, required 8", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (data_rx !== 8'(i) || count !== 4'(DEPTH - i) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL fill_order[%0d]: data=%h count=%0d ovf=%b, required %h %0d 0",
                 i, data_rx, count, overflow, 8'(i), DEPTH - i);
      end
      data_rx_ack = 1;
      step();
      data_rx_ack = 0;
    end
    checks++;
    if (count !== 4'd0 || have_data_rx !== 1'b0) begin
      errors++;
      $display("FAIL fill_drained: count=%0d have=%b, required 0 0", count, have_data_rx);
    end
  endtask

  task automatic test_overflow();
    fill_0_to_7();
    core_data_rx = 8'hEE; core_have_data_rx = 1;
    step();
    core_have_data_rx = 0;
    checks++;
    if (core_data_rx_ack !== 1'b1 || overflow !== 1'b1 || count !== 4'd8 || data_rx !== 8'h00) begin
      errors++;
      $display("FAIL overflow_drop: ack=%b ovf=%b count=%0d head=%h, required 1 1 8 00",
               core_data_rx_ack, overflow, count, data_rx);
    end
    step(); step();
    overflow_clr = 1;
    step();
    overflow_clr = 0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: ovf=%b, required 0", overflow);
    end
    core_data_rx = 8'hEF; core_have_data_rx = 1; overflow_clr = 1;
    step();
    core_have_data_rx = 0; overflow_clr = 0;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow_set_wins: ovf=%b count=%0d, required 1 8", overflow, count);
    end
    step(); step();
  endtask

  // FIFO still full with 00..07 from the overflow test.
  task automatic test_simul_full();
    overflow_clr = 1;
    step();
    overflow_clr = 0;
    core_data_rx = 8'h99; core_have_data_rx = 1; data_rx_ack = 1;
    step();
    core_have_data_rx = 0; data_rx_ack = 0;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || data_rx !== 8'h01) begin
      errors++;
      $display("FAIL simul_full: count=%0d ovf=%b head=%h, required 8 0 01",
               count, overflow, data_rx);
    end
    step(); step();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (data_rx !== ((i == DEPTH - 1) ? 8'h99 : 8'(i + 1))) begin
        errors++;
        $display("FAIL simul_drain[%0d]: data=%h, required %h", i, data_rx,
                 (i == DEPTH - 1) ? 8'h99 : 8'(i + 1));
      end
      data_rx_ack = 1;
      step();
      data_rx_ack = 0;
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    core_data_rx = 8'h77; core_have_data_rx = 1; flush = 1;
    step();
    core_have_data_rx = 0; flush = 0;
    checks++;
    if (count !== 4'd0 || have_data_rx !== 1'b0 || core_data_rx_ack !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d have=%b ack=%b, required 0 0 1",
               count, have_data_rx, core_data_rx_ack);
    end
    step();
    checks++;
    if (core_data_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack_len: ack=%b, required 0", core_data_rx_ack);
    end
    step();
    push_byte(8'h11);
    core_data_rx = 8'h22; core_have_data_rx = 1;
    step();
    rst = 1; core_have_data_rx = 0;
    step();
    rst = 0;
    checks++;
    if (core_data_rx_ack !== 1'b0 || count !== 4'd0 || have_data_rx !== 1'b0 ||
        data_rx !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ack: ack=%b count=%0d have=%b data=%h ovf=%b, required 0 0 0 00 0",
               core_data_rx_ack, count, have_data_rx, data_rx, overflow);
    end
  endtask

  task automatic test_empty_pop();
    data_rx_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 4'd0 || have_data_rx !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL empty_pop[%0d]: count=%0d have=%b ovf=%b, required 0 0 0",
                 i, count, have_data_rx, overflow);
      end
    end
    data_rx_ack = 0;
    push_byte(8'h5C);
    checks++;
    if (data_rx !== 8'h5C || count !== 4'd1) begin
      errors++;
      $display("FAIL empty_pop_ptr: data=%h count=%0d, required 5c 1", data_rx, count);
    end
    data_rx_ack = 1;
    step();
    data_rx_ack = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst               = ($urandom_range(0, 199) == 0);
      core_data_rx      = 8'($urandom());
      core_have_data_rx = ($urandom_range(0, 99) < 60);
      data_rx_ack       = ($urandom_range(0, 99) < ((n / 100) % 2 == 0 ? 15 : 55));
      flush             = ($urandom_range(0, 79) == 0);
      overflow_clr      = ($urandom_range(0, 29) == 0);
      step();
      checks++;
      if (count !== 4'(mq.size()) || have_data_rx !== (mq.size() != 0) ||
          data_rx !== ((mq.size() != 0) ? mq[0] : 8'h00) ||
          overflow !== m_ovf || core_data_rx_ack !== m_ack) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d have=%b data=%h ovf=%b ack=%b, required %0d %b %h %b %b",
                 n, count, have_data_rx, data_rx, overflow, core_data_rx_ack,
                 mq.size(), mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00, m_ovf, m_ack);
      end
    end
    idle_inputs();
    step(); step(); step();
  endtask

  initial begin
    m_ovf = 0; m_ack = 0; m_busy = 0;
    test_reset();
    test_single();
    test_fill();
    test_overflow();
    test_simul_full();
    test_flush_reset();
    test_empty_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
